// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared I2S constants, state encoding and frame packing helper,
//               common to the transmitter and the microphone receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int SLOT_WIDTH   = 32;
  localparam int FRAME_BITS   = 64;
  localparam int BIT_CNT_W    = $clog2(FRAME_BITS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_e;

  // Builds one stereo frame: left slot then right slot, each sample MSB-first
  // and left-justified in its slot, remaining slot bits zero.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [SAMPLE_WIDTH-1:0] left,
    input logic [SAMPLE_WIDTH-1:0] right
  );
    return {left,  {(SLOT_WIDTH-SAMPLE_WIDTH){1'b0}},
            right, {(SLOT_WIDTH-SAMPLE_WIDTH){1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2s_clk_gen
// Description : SCK divider. While run_i is high, SCK toggles every SCK_DIV
//               clk_i cycles (first toggle SCK_DIV cycles after run_i rises).
//               rise_o/fall_o flag the cycle whose clock edge makes SCK rise
//               or fall, so callers update in lockstep with SCK.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_clk_gen #(
  parameter int SCK_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CNT_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             w_tick;

  assign w_tick = run_i && (cnt_q == CNT_LAST);
  assign rise_o = w_tick && !sck_q;
  assign fall_o = w_tick &&  sck_q;
  assign sck_o  = sck_q;

  // Divider next state: parked at zero with SCK low whenever not running.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!run_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (w_tick) begin
      cnt_d = '0;
      sck_d = !sck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : i2s_transmitter
// Description : Stereo 16-bit I2S master transmitter with a one-pair holding
//               buffer, frame-boundary enable, and underrun signalling.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int SCK_DIV = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         enable_in,
  input  logic [1:0][SAMPLE_WIDTH-1:0] audio_data_in,
  input  logic                         audio_valid_in,
  output logic                         audio_ready_out,
  output logic                         i2s_sck_out,
  output logic                         i2s_ws_out,
  output logic                         i2s_sd_out,
  output logic                         underrun_out
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  logic [1:0]                    rst_sync_q;
  logic                          w_rst_n;
  i2s_state_e                    state_q, state_d;
  logic [1:0][SAMPLE_WIDTH-1:0]  buf_q, buf_d;
  logic                          buf_full_q, buf_full_d;
  logic [FRAME_BITS-1:0]         frame_q, frame_d;
  logic [BIT_CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [BIT_CNT_W-1:0]          w_bit_next;
  logic                          underrun_q, underrun_d;
  logic                          w_run;
  logic                          w_sck_fall;
  logic                          unused_sck_rise;

  // Reset asserts immediately, releases two clk_in edges after rst_in rises.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign w_rst_n = rst_sync_q[1];

  assign w_run = (state_q == RUN);

  i2s_clk_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_clk_gen (
    .clk_i  (clk_in),
    .rst_ni (w_rst_n),
    .run_i  (w_run),
    .sck_o  (i2s_sck_out),
    .rise_o (unused_sck_rise),
    .fall_o (w_sck_fall)
  );

  // WS leads the slot by one bit: it follows bit 5 of the upcoming bit index.
  assign w_bit_next      = bit_cnt_q + 1'b1;
  assign i2s_ws_out      = w_run && w_bit_next[BIT_CNT_W-1];
  assign i2s_sd_out      = frame_q[FRAME_BITS-1];
  assign audio_ready_out = !buf_full_q;
  assign underrun_out    = underrun_q;

  // Buffer handshake, frame loading/shifting and IDLE/RUN transitions.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    underrun_d = 1'b0;

    // A pair offered while empty is always captured, even on a boundary edge;
    // the boundary decision below only looks at the pre-edge buffer state.
    if (audio_valid_in && !buf_full_q) begin
      buf_d      = audio_data_in;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (buf_full_q && enable_in) begin
          state_d    = RUN;
          frame_d    = pack_frame(buf_q[0], buf_q[1]);
          buf_full_d = 1'b0;
          bit_cnt_d  = '0;
        end
      end
      RUN: begin
        if (w_sck_fall) begin
          bit_cnt_d = w_bit_next;
          frame_d   = {frame_q[FRAME_BITS-2:0], 1'b0};
          if (bit_cnt_q == LAST_BIT) begin
            if (!enable_in) begin
              state_d = IDLE;
              frame_d = '0;
            end else if (buf_full_q) begin
              frame_d    = pack_frame(buf_q[0], buf_q[1]);
              buf_full_d = 1'b0;
            end else begin
              frame_d    = '0;
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and FSM registers; reset drops any frame in flight and the buffer.
  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      underrun_q <= underrun_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_transmitter
// Description : Self-checking bench for i2s_transmitter. A negedge monitor
//               records SCK rise/fall times, SD/WS at each SCK rise, WS rises
//               and underrun pulses; scenario tasks compare these against
//               frames and timings computed from the I2S frame format.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_transmitter;

  localparam int SCK_DIV   = 16;
  localparam int BIT_CYC   = 2 * SCK_DIV;
  localparam int FRAME_CYC = 64 * BIT_CYC;
  localparam int BUDGET    = 3 * FRAME_CYC;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             enable_in = 1'b0;
  logic [1:0][15:0] audio_data_in = '0;
  logic             audio_valid_in = 1'b0;
  logic             audio_ready_out;
  logic             i2s_sck_out, i2s_ws_out, i2s_sd_out, underrun_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit sd_q[$];
  bit ws_q[$];
  int rise_t[$];
  int fall_t[$];
  int wsr_t[$];
  int und_t[$];
  logic sck_prev = 1'b0;
  logic ws_prev  = 1'b0;

  i2s_transmitter #(.SCK_DIV(SCK_DIV)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .audio_data_in   (audio_data_in),
    .audio_valid_in  (audio_valid_in),
    .audio_ready_out (audio_ready_out),
    .i2s_sck_out     (i2s_sck_out),
    .i2s_ws_out      (i2s_ws_out),
    .i2s_sd_out      (i2s_sd_out),
    .underrun_out    (underrun_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Line monitor, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (i2s_sck_out && !sck_prev) begin
      sd_q.push_back(i2s_sd_out);
      ws_q.push_back(i2s_ws_out);
      rise_t.push_back(cyc);
    end
    if (!i2s_sck_out && sck_prev) fall_t.push_back(cyc);
    if (i2s_ws_out && !ws_prev) wsr_t.push_back(cyc);
    if (underrun_out) und_t.push_back(cyc);
    sck_prev <= i2s_sck_out;
    ws_prev  <= i2s_ws_out;
  end

  // Reference frame: left sample in slot 0, right in slot 1, MSB first.
  function automatic logic [63:0] frame_of(input logic [15:0] l, input logic [15:0] r);
    return {l, 16'h0000, r, 16'h0000};
  endfunction

  // Reference WS as seen at bit k of a frame: right channel for bits 31..62.
  function automatic logic [63:0] ws_ref();
    logic [63:0] p;
    for (int k = 0; k < 64; k++) p[63-k] = (k >= 31) && (k <= 62);
    return p;
  endfunction

  function automatic logic [63:0] sd_obs(input int base);
    logic [63:0] v;
    for (int k = 0; k < 64; k++) v[63-k] = (base + k < sd_q.size()) ? sd_q[base+k] : 1'b0;
    return v;
  endfunction

  function automatic logic [63:0] ws_obs(input int base);
    logic [63:0] v;
    for (int k = 0; k < 64; k++) v[63-k] = (base + k < ws_q.size()) ? ws_q[base+k] : 1'b0;
    return v;
  endfunction

  function automatic int rt(input int i);
    return (i < rise_t.size()) ? rise_t[i] : -1;
  endfunction

  task automatic flush();
    sd_q.delete(); ws_q.delete(); rise_t.delete();
    fall_t.delete(); wsr_t.delete(); und_t.delete();
  endtask

  task automatic do_reset();
    enable_in      = 1'b0;
    audio_valid_in = 1'b0;
    rst_in         = 1'b0;
    repeat (4) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (4) @(negedge clk_in);
    flush();
  endtask

  // Offers one pair; t = cycle stamp of the negedge just after acceptance.
  task automatic push(input logic [15:0] l, input logic [15:0] r, output int t);
    int n = 0;
    while (!audio_ready_out && n < BUDGET) begin
      @(negedge clk_in);
      n++;
    end
    if (!audio_ready_out) begin
      checks++; errors++;
      $display("FAIL push_timeout ready=%0b required 1", audio_ready_out);
      t = -1;
    end else begin
      audio_data_in[0] = l;
      audio_data_in[1] = r;
      audio_valid_in   = 1'b1;
      @(negedge clk_in);
      audio_valid_in = 1'b0;
      audio_data_in  = {16'($urandom), 16'($urandom)};
      t = cyc;
    end
  endtask

  task automatic wait_rises(input int n);
    int c = 0;
    while (rise_t.size() < n && c < BUDGET) begin
      @(negedge clk_in);
      c++;
    end
    if (rise_t.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_rises got %0d required %0d", rise_t.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
    checks++;
    if (audio_ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", audio_ready_out); end
    checks++;
    if ({i2s_sck_out, i2s_ws_out, i2s_sd_out, underrun_out} !== 4'b0000) begin
      errors++; $display("FAIL rst_outputs got %b want 0000", {i2s_sck_out, i2s_ws_out, i2s_sd_out, underrun_out});
    end
    rst_in = 1'b1;
    flush();
    repeat (100) @(negedge clk_in);
    checks++;
    if (rise_t.size() != 0) begin errors++; $display("FAIL rst_idle_sck got %0d rises want 0", rise_t.size()); end
    checks++;
    if ({audio_ready_out, i2s_sck_out, i2s_ws_out, i2s_sd_out} !== 4'b1000) begin
      errors++; $display("FAIL rst_idle_outputs got %b want 1000", {audio_ready_out, i2s_sck_out, i2s_ws_out, i2s_sd_out});
    end
  endtask

  task automatic test_frame();
    int t;
    do_reset();
    enable_in = 1'b1;
    push(16'hA5C3, 16'h8001, t);
    wait_rises(128);
    checks++;
    if (sd_obs(0) !== frame_of(16'hA5C3, 16'h8001)) begin
      errors++; $display("FAIL frame_sd got %h want %h", sd_obs(0), frame_of(16'hA5C3, 16'h8001));
    end
    checks++;
    if (ws_obs(0) !== ws_ref()) begin errors++; $display("FAIL frame_ws got %h want %h", ws_obs(0), ws_ref()); end
    checks++;
    if (rt(0) != t + 1 + SCK_DIV) begin errors++; $display("FAIL first_rise got %0d want %0d", rt(0), t + 1 + SCK_DIV); end
    checks++;
    if (rt(1) - rt(0) != BIT_CYC) begin errors++; $display("FAIL sck_period got %0d want %0d", rt(1) - rt(0), BIT_CYC); end
    checks++;
    if (fall_t.size() < 1 || fall_t[0] - rt(0) != SCK_DIV) begin
      errors++; $display("FAIL sck_high got %0d want %0d", (fall_t.size() > 0) ? fall_t[0] - rt(0) : -1, SCK_DIV);
    end
    checks++;
    if (rt(64) - rt(0) != FRAME_CYC) begin errors++; $display("FAIL frame_len got %0d want %0d", rt(64) - rt(0), FRAME_CYC); end
    checks++;
    if (wsr_t.size() < 2 || wsr_t[1] - wsr_t[0] != FRAME_CYC) begin
      errors++; $display("FAIL ws_period got %0d want %0d", (wsr_t.size() > 1) ? wsr_t[1] - wsr_t[0] : -1, FRAME_CYC);
    end
    checks++;
    if (sd_obs(64) !== 64'h0) begin errors++; $display("FAIL frame2_zero got %h want 0", sd_obs(64)); end
    checks++;
    if (ws_obs(64) !== ws_ref()) begin errors++; $display("FAIL frame2_ws got %h want %h", ws_obs(64), ws_ref()); end
    checks++;
    if (und_t.size() != 1 || und_t[0] != rt(64) - SCK_DIV) begin
      errors++; $display("FAIL frame_underrun got n=%0d t=%0d want n=1 t=%0d", und_t.size(),
                         (und_t.size() > 0) ? und_t[0] : -1, rt(64) - SCK_DIV);
    end
  endtask

  task automatic test_underrun();
    int t;
    logic [15:0] l, r;
    do_reset();
    l = 16'($urandom); r = 16'($urandom);
    enable_in = 1'b1;
    push(l, r, t);
    wait_rises(192);
    checks++;
    if (sd_obs(0) !== frame_of(l, r)) begin errors++; $display("FAIL ur_frame got %h want %h", sd_obs(0), frame_of(l, r)); end
    checks++;
    if ({sd_obs(64), sd_obs(128)} !== 128'h0) begin
      errors++; $display("FAIL ur_zero got %h %h want 0", sd_obs(64), sd_obs(128));
    end
    checks++;
    if (und_t.size() != 2) begin errors++; $display("FAIL ur_count got %0d want 2", und_t.size()); end
    checks++;
    if (und_t.size() < 1 || und_t[0] != rt(64) - SCK_DIV) begin
      errors++; $display("FAIL ur_time got %0d want %0d", (und_t.size() > 0) ? und_t[0] : -1, rt(64) - SCK_DIV);
    end
    checks++;
    if (und_t.size() < 2 || und_t[1] - und_t[0] != FRAME_CYC) begin
      errors++; $display("FAIL ur_period got %0d want %0d", (und_t.size() > 1) ? und_t[1] - und_t[0] : -1, FRAME_CYC);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pl[5];
    logic [15:0] pr[5];
    int acc[5];
    int nacc = 0;
    int n = 0;
    logic rdy_prev;
    do_reset();
    for (int i = 0; i < 5; i++) begin pl[i] = 16'($urandom); pr[i] = 16'($urandom); acc[i] = -1; end
    enable_in        = 1'b1;
    audio_data_in[0] = pl[0];
    audio_data_in[1] = pr[0];
    audio_valid_in   = 1'b1;
    rdy_prev         = audio_ready_out;
    while (rise_t.size() < 256 && n < 5 * FRAME_CYC) begin
      @(negedge clk_in);
      n++;
      if (audio_valid_in && rdy_prev) begin
        if (nacc < 5) acc[nacc] = cyc;
        nacc++;
        if (nacc < 5) begin
          audio_data_in[0] = pl[nacc];
          audio_data_in[1] = pr[nacc];
        end else begin
          audio_valid_in = 1'b0;
        end
      end
      rdy_prev = audio_ready_out;
    end
    audio_valid_in = 1'b0;
    checks++;
    if (rise_t.size() < 256) begin errors++; $display("FAIL b2b_timeout got %0d rises want 256", rise_t.size()); end
    for (int f = 0; f < 4; f++) begin
      checks++;
      if (sd_obs(64 * f) !== frame_of(pl[f], pr[f])) begin
        errors++; $display("FAIL b2b_frame%0d got %h want %h", f, sd_obs(64 * f), frame_of(pl[f], pr[f]));
      end
    end
    checks++;
    if (und_t.size() != 0) begin errors++; $display("FAIL b2b_underrun got %0d want 0", und_t.size()); end
    checks++;
    if (nacc != 5) begin errors++; $display("FAIL b2b_accepts got %0d want 5", nacc); end
    checks++;
    if (acc[1] != acc[0] + 2) begin errors++; $display("FAIL b2b_acc1 got %0d want %0d", acc[1], acc[0] + 2); end
    for (int k = 2; k < 5; k++) begin
      checks++;
      if (acc[k] != rt(64 * (k - 1)) - SCK_DIV + 1) begin
        errors++; $display("FAIL b2b_acc%0d got %0d want %0d", k, acc[k], rt(64 * (k - 1)) - SCK_DIV + 1);
      end
    end
  endtask

  task automatic test_enable_drop();
    int ta, tb;
    logic [15:0] al, ar, bl, br;
    do_reset();
    al = 16'($urandom); ar = 16'($urandom); bl = 16'($urandom); br = 16'($urandom);
    enable_in = 1'b1;
    push(al, ar, ta);
    push(bl, br, tb);
    wait_rises(21);
    enable_in = 1'b0;
    wait_rises(64);
    repeat (SCK_DIV + 200) @(negedge clk_in);
    checks++;
    if (rise_t.size() != 64) begin errors++; $display("FAIL en_stop got %0d rises want 64", rise_t.size()); end
    checks++;
    if ({i2s_sck_out, i2s_ws_out, i2s_sd_out} !== 3'b000) begin
      errors++; $display("FAIL en_idle_out got %b want 000", {i2s_sck_out, i2s_ws_out, i2s_sd_out});
    end
    checks++;
    if (audio_ready_out !== 1'b0) begin errors++; $display("FAIL en_retained got ready=%b want 0", audio_ready_out); end
    checks++;
    if (sd_obs(0) !== frame_of(al, ar)) begin errors++; $display("FAIL en_frameA got %h want %h", sd_obs(0), frame_of(al, ar)); end
    enable_in = 1'b1;
    wait_rises(128);
    checks++;
    if (sd_obs(64) !== frame_of(bl, br)) begin errors++; $display("FAIL en_frameB got %h want %h", sd_obs(64), frame_of(bl, br)); end
    checks++;
    if (und_t.size() != 0) begin errors++; $display("FAIL en_underrun got %0d want 0", und_t.size()); end
  endtask

  task automatic test_reset_mid();
    int t, n0;
    logic [15:0] cl, cr;
    do_reset();
    cl = 16'($urandom); cr = 16'($urandom);
    enable_in = 1'b1;
    push(16'($urandom), 16'($urandom), t);
    push(16'($urandom), 16'($urandom), t);
    wait_rises(21);
    #1 rst_in = 1'b0;
    #1;
    checks++;
    if ({i2s_sck_out, i2s_ws_out, i2s_sd_out, underrun_out} !== 4'b0000) begin
      errors++; $display("FAIL rm_outputs got %b want 0000", {i2s_sck_out, i2s_ws_out, i2s_sd_out, underrun_out});
    end
    checks++;
    if (audio_ready_out !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", audio_ready_out); end
    n0 = rise_t.size();
    @(negedge clk_in);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (300) @(negedge clk_in);
    checks++;
    if (rise_t.size() != n0 || i2s_sck_out !== 1'b0) begin
      errors++; $display("FAIL rm_quiet got %0d rises sck=%b want %0d sck=0", rise_t.size(), i2s_sck_out, n0);
    end
    flush();
    push(cl, cr, t);
    wait_rises(64);
    checks++;
    if (sd_obs(0) !== frame_of(cl, cr)) begin errors++; $display("FAIL rm_frame got %h want %h", sd_obs(0), frame_of(cl, cr)); end
    checks++;
    if (rt(0) != t + 1 + SCK_DIV) begin errors++; $display("FAIL rm_first_rise got %0d want %0d", rt(0), t + 1 + SCK_DIV); end
  endtask

  initial begin
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    test_reset();
    test_frame();
    test_underrun();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter SCK_DIV, default 16, meaning clk_in cycles per half SCK period (98.304 MHz / 32 = 3.072 MHz SCK, 48 kHz frame).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port: clk_in  input  1  system clock (clk_m domain).
REQ-004 SHALL have port: rst_in  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: enable_in  input  1  run request, sampled at frame boundaries.
REQ-006 SHALL have port: audio_data_in  input  2x16 signed  [0]=left, [1]=right sample.
REQ-007 SHALL have port: audio_valid_in  input  1  sample-pair valid.
REQ-008 SHALL have port: audio_ready_out  output  1  holding buffer empty.
REQ-009 SHALL have port: i2s_sck_out  output  1  serial bit clock.
REQ-010 SHALL have port: i2s_ws_out  output  1  word select, 0=left, 1=right.
REQ-011 SHALL have port: i2s_sd_out  output  1  serial data, MSB first.
REQ-012 SHALL have port: underrun_out  output  1  one-cycle pulse when a frame starts with no sample buffered.

Function
REQ-013 SHALL hold one sample pair in a holding buffer; audio_ready_out = buffer empty; a pair is accepted on an edge where valid and ready are both high.
REQ-014 SHALL implement states IDLE and RUN; in IDLE, sck, ws and sd SHALL be held at 0.
REQ-015 IDLE->RUN SHALL occur on the first edge where the buffer is full and enable_in is high. On that edge the frame register SHALL load {L,16'b0,R,16'b0}, the buffer SHALL empty, bit_cnt SHALL be 0, sck 0, ws 0, and sd SHALL equal L[15].
REQ-016 In RUN, sck SHALL toggle every SCK_DIV clk_in cycles, starting SCK_DIV cycles after entry.
REQ-017 On each sck falling edge, bit_cnt (6-bit) SHALL increment, wrapping 63->0, and the frame register SHALL shift left by one; sd SHALL always equal frame register bit 63.
REQ-018 ws SHALL equal bit 5 of (bit_cnt+1) mod 64: high during bits 31..62, low during bit 63 and bits 0..30. This gives the one-SCK I2S delay between a ws change and the MSB.
REQ-019 At the falling edge where bit_cnt wraps to 0 (the frame boundary), if enable_in is low, the block SHALL go to IDLE; sck/ws/sd SHALL be 0 on that edge and the buffer SHALL be retained.
REQ-020 At a frame boundary with enable_in high and the buffer full, the block SHALL load the buffer into the frame register and empty the buffer.
REQ-021 At a frame boundary with enable_in high and the buffer empty, the block SHALL load all zeros, pulse underrun_out for exactly one cycle, and stay in RUN.
REQ-022 The boundary load SHALL use the buffer contents held before the edge. A pair accepted on the boundary edge itself SHALL be buffered for the next frame, and that frame SHALL still count as an underrun.
REQ-023 Samples SHALL be sent unmodified, two's complement; slot bits 16..31 SHALL be 0.
REQ-024 Sample rate SHALL be clk_in / (128*SCK_DIV); audio_ready_out SHALL rise at most once per frame in steady state.

Reset
REQ-025 Asserting rst_in low SHALL immediately force: state IDLE; sck/ws/sd/underrun_out to 0; audio_ready_out to 1; buffer empty; all counters 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no partial completion, and SHALL discard any buffered pair.
REQ-027 Deassertion SHALL be synchronised to clk_in with a 2-flop synchroniser before internal logic leaves reset.

Structure
REQ-028 Package i2s_pkg SHALL hold SAMPLE_WIDTH=16, SLOT_WIDTH=32, FRAME_BITS=64 and the state enum {IDLE, RUN}, shared with the microphones receiver.
REQ-029 SCK generation (divider counter, rise/fall event strobes) SHALL be one sub-module, i2s_clk_gen; the buffer, shift logic and FSM SHALL stay in i2s_transmitter.

Verification
REQ-030 The bench SHALL cover: enable high, push L=16'hA5C3, R=16'h8001 -> sd on successive falling edges reads 1010010111000011, 16 zeros, 1000000000000001, 16 zeros; ws low for bits 63,0..30 and high for 31..62.
REQ-031 The bench SHALL cover: SCK_DIV=16 -> sck period 32 clk_in cycles; frame length 2048 cycles; ws period 2048 cycles.
REQ-032 The bench SHALL cover: push one pair, then no more -> the next frame is all zeros, underrun_out pulses once at bit_cnt 0, and the pulse repeats every 2048 cycles.
REQ-033 The bench SHALL cover: valid held high continuously -> exactly one accept per frame, no underrun, and the next pair is accepted the cycle after each boundary load.
REQ-034 The bench SHALL cover: enable_in dropped mid-frame -> the frame completes, IDLE at the boundary with outputs 0, and a buffered pair is transmitted first after re-enable.
REQ-035 The bench SHALL cover: rst_in pulsed low at bit 20 -> outputs 0 within the same cycle, audio_ready_out=1, and no sck activity until a new pair is pushed.
